// File: rtl/debounce_pkg.sv
// Shared encodings for the debounce filter: FSM state codes and the idle level
// of the active-low button signals.
package debounce_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Idle (not pressed) level of every active-low signal in this path.
  localparam logic LEVEL_RESET_N = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous active-low input.
// Both stages reset to the idle level, so no press is seen while in reset.
module sync_2ff
  import debounce_pkg::*;
(
  input  logic clk_db,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: registers are always written with <= so every flop samples the
  // values from before the edge; with = the second stage would see d directly.
  always_ff @(posedge clk_db or negedge reset_n) begin
    if (!reset_n) begin
      meta <= LEVEL_RESET_N;
      q    <= LEVEL_RESET_N;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// Debounces a raw active-low contact into a stable active-low level and keeps
// a saturating count of aborted transitions for bring-up diagnostics.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH     = 20,
  parameter int unsigned GLITCH_WIDTH  = 8
) (
  input  logic                    clk_db,
  input  logic                    reset_n,
  input  logic                    signal_raw_n,
  input  logic                    clear_glitch,
  output logic                    signal_debounced_n,
  output logic [GLITCH_WIDTH-1:0] glitch_count
);

  localparam logic [CNT_WIDTH-1:0]    CNT_LAST   = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = {GLITCH_WIDTH{1'b1}};

  logic                 s;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 glitch_evt;

  sync_2ff u_sync (
    .clk_db  (clk_db),
    .reset_n (reset_n),
    .d       (signal_raw_n),
    .q       (s)
  );

  // A wait state that sees the old level again has aborted its transition.
  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left glitch_evt unassigned would infer a latch.
  always_comb begin
    glitch_evt = 1'b0;
    if (state == ST_PRESS_WAIT && s)
      glitch_evt = 1'b1;
    else if (state == ST_RELEASE_WAIT && !s)
      glitch_evt = 1'b1;
  end

  always_ff @(posedge clk_db or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_RELEASED;
      cnt                <= '0;
      signal_debounced_n <= LEVEL_RESET_N;
    end else begin
      case (state)
        ST_RELEASED: begin
          if (!s) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (s) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state              <= ST_PRESSED;
            cnt                <= '0;
            signal_debounced_n <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (s) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state              <= ST_RELEASED;
            cnt                <= '0;
            signal_debounced_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state              <= ST_RELEASED;
          cnt                <= '0;
          signal_debounced_n <= LEVEL_RESET_N;
        end
      endcase
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk_db or negedge reset_n) begin
    if (!reset_n)
      glitch_count <= '0;
    else if (clear_glitch)
      glitch_count <= '0;
    else if (glitch_evt && glitch_count != GLITCH_MAX)
      glitch_count <= glitch_count + 1'b1;
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter (STABLE_CYCLES=4, GLITCH_WIDTH=3):
// stimulus queues expected output changes, a monitor matches every change.
module tb_debounce_filter;
  import debounce_pkg::*;

  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned CNT_WIDTH     = 3;
  localparam int unsigned GLITCH_WIDTH  = 3;
  localparam int unsigned LAT           = STABLE_CYCLES + 2;

  logic                    clk_db;
  logic                    reset_n;
  logic                    signal_raw_n;
  logic                    clear_glitch;
  logic                    signal_debounced_n;
  logic [GLITCH_WIDTH-1:0] glitch_count;

  debounce_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH),
    .GLITCH_WIDTH  (GLITCH_WIDTH)
  ) dut (
    .clk_db             (clk_db),
    .reset_n            (reset_n),
    .signal_raw_n       (signal_raw_n),
    .clear_glitch       (clear_glitch),
    .signal_debounced_n (signal_debounced_n),
    .glitch_count       (glitch_count)
  );

  initial clk_db = 1'b0;
  always #5 clk_db = ~clk_db;

  typedef struct packed {
    logic [31:0]             cyc;
    logic                    db;
    logic [GLITCH_WIDTH-1:0] gc;
  } ev_t;

  ev_t                     exp_q[$];
  int unsigned             cyc      = 0;
  int unsigned             n_checks = 0;
  int unsigned             n_pass   = 0;
  logic                    prev_db  = 1'b1;
  logic [GLITCH_WIDTH-1:0] prev_gc  = '0;
  int unsigned             exp_gc;

  always @(posedge clk_db) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int unsigned at, input logic db, input int unsigned gc);
    exp_q.push_back('{cyc: at, db: db, gc: GLITCH_WIDTH'(gc)});
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk_db);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_db);
      n++;
    end
    check("pending_events", exp_q.size(), 0);
    exp_q.delete();
    hold(8);
  endtask

  // Monitor: every visible output change must match the next queued event.
  always @(negedge clk_db) begin
    if (signal_debounced_n !== prev_db || glitch_count !== prev_gc) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_change: db=%b gc=%0d at cycle %0d, expected no change",
                 signal_debounced_n, glitch_count, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_debounced", 32'(signal_debounced_n), 32'(e.db));
        check("ev_glitch", 32'(glitch_count), 32'(e.gc));
      end
      prev_db = signal_debounced_n;
      prev_gc = glitch_count;
    end
  end

  initial begin
    reset_n      = 1'b0;
    signal_raw_n = 1'b0;
    clear_glitch = 1'b0;

    // 1. Reset held with the button pressed, then released.
    repeat (4) begin
      @(negedge clk_db);
      check("reset_debounced", 32'(signal_debounced_n), 1);
      check("reset_glitch", 32'(glitch_count), 0);
    end
    @(posedge clk_db); #1;
    expect_ev(cyc + LAT, 1'b0, 0);
    reset_n = 1'b1;
    drain(50);

    // 2. Clean release, press held 20 cycles, release.
    expect_ev(cyc + LAT, 1'b1, 0);
    signal_raw_n = 1'b1;
    drain(50);
    expect_ev(cyc + LAT, 1'b0, 0);
    signal_raw_n = 1'b0;
    hold(20);
    expect_ev(cyc + LAT, 1'b1, 0);
    signal_raw_n = 1'b1;
    drain(50);
    check("clean_glitch", 32'(glitch_count), 0);

    // 3. Bounce: low 2, high 1, low 3, high 1, then steady low.
    expect_ev(cyc + 5,  1'b1, 1);
    expect_ev(cyc + 9,  1'b1, 2);
    expect_ev(cyc + 13, 1'b0, 2);
    signal_raw_n = 1'b0; hold(2);
    signal_raw_n = 1'b1; hold(1);
    signal_raw_n = 1'b0; hold(3);
    signal_raw_n = 1'b1; hold(1);
    signal_raw_n = 1'b0;
    drain(50);
    expect_ev(cyc + LAT, 1'b1, 2);
    signal_raw_n = 1'b1;
    drain(50);

    // 4. Clear, nine short pulses to saturation, then clear racing a glitch.
    expect_ev(cyc + 1, 1'b1, 0);
    clear_glitch = 1'b1; hold(1);
    clear_glitch = 1'b0;
    exp_gc = 0;
    for (int i = 0; i < 9; i++) begin
      if (exp_gc < 7) begin
        exp_gc++;
        expect_ev(cyc + 5, 1'b1, exp_gc);
      end
      signal_raw_n = 1'b0; hold(2);
      signal_raw_n = 1'b1; hold(2);
    end
    drain(50);
    check("saturated_glitch", 32'(glitch_count), 7);
    expect_ev(cyc + 5, 1'b1, 0);
    signal_raw_n = 1'b0; hold(2);
    signal_raw_n = 1'b1; hold(2);
    clear_glitch = 1'b1; hold(1);
    clear_glitch = 1'b0;
    drain(50);
    check("cleared_glitch", 32'(glitch_count), 0);

    // 6. Release-side glitch while pressed.
    expect_ev(cyc + LAT, 1'b0, 0);
    signal_raw_n = 1'b0;
    drain(50);
    expect_ev(cyc + 6, 1'b0, 1);
    signal_raw_n = 1'b1; hold(3);
    signal_raw_n = 1'b0;
    drain(50);
    check("release_glitch_level", 32'(signal_debounced_n), 0);

    // 5. Reset pulse while in RELEASE_WAIT with cnt=2.
    signal_raw_n = 1'b1;
    hold(4);
    check("mid_wait_state", 32'(dut.state), 32'(ST_RELEASE_WAIT));
    check("mid_wait_cnt", 32'(dut.cnt), 2);
    expect_ev(cyc, 1'b1, 0);
    reset_n = 1'b0;
    #1;
    check("async_reset_level", 32'(signal_debounced_n), 1);
    hold(1);
    reset_n = 1'b1;
    #1;
    check("post_reset_state", 32'(dut.state), 32'(ST_RELEASED));
    check("post_reset_cnt", 32'(dut.cnt), 0);
    drain(50);
    expect_ev(cyc + LAT, 1'b0, 0);
    signal_raw_n = 1'b0;
    drain(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/debounce_filter.md
Name: debounce_filter

Overview:
- Cleans a raw, bouncing, active-low mechanical input (push-button or switch) into a stable active-low level.
- Sits directly upstream of the one-pulse stage; its signal_debounced_n drives that stage's source input, on the same clock and reset.
- Also counts rejected bounces/glitches for board bring-up diagnostics.

Parameters:
STABLE_CYCLES, 1000000, consecutive synchronized samples at one level needed to accept that level; legal range is 2 or more.
CNT_WIDTH, 20, width of the stability counter; the implementation must satisfy 2**CNT_WIDTH > STABLE_CYCLES.
GLITCH_WIDTH, 8, width of the saturating glitch counter.

Ports:
clk_db  input  1  sampling/filter clock
reset_n  input  1  asynchronous, active-low reset
signal_raw_n  input  1  raw asynchronous active-low input (0 = pressed)
clear_glitch  input  1  synchronous, active-high clear of glitch_count
signal_debounced_n  output  1  debounced active-low level, registered
glitch_count  output  GLITCH_WIDTH  saturating count of aborted transitions, registered

Behaviour:
- Reset (reset_n=0, asynchronous, one clock, active-low):
  - both synchronizer flops = 1
  - state = RELEASED, counter = 0
  - signal_debounced_n = 1, glitch_count = 0
- Synchronizer: two flops on signal_raw_n; the second flop's output is s. The FSM uses only s.
- FSM states and transitions, evaluated each clk_db rising edge:
  - RELEASED: if s=0, go to PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT, s=0: if cnt==STABLE_CYCLES-1, go to PRESSED with signal_debounced_n=0 and cnt=0; else cnt++.
  - PRESS_WAIT, s=1: go to RELEASED with cnt=0 and glitch_count++ (saturating).
  - PRESSED: if s=1, go to RELEASE_WAIT with cnt=1; otherwise stay.
  - RELEASE_WAIT, s=1: if cnt==STABLE_CYCLES-1, go to RELEASED with signal_debounced_n=1 and cnt=0; else cnt++.
  - RELEASE_WAIT, s=0: go to PRESSED with cnt=0 and glitch_count++ (saturating).
- Latency:
  - The output changes on the (STABLE_CYCLES+2)-th rising edge after the edge that first captures a new raw level, provided the raw level holds throughout.
  - Breakdown: 2 synchronizer edges, then STABLE_CYCLES samples.
- signal_debounced_n changes only on transitions into PRESSED or RELEASED. It never glitches and holds its value in both WAIT states.
- glitch_count:
  - Saturates at 2**GLITCH_WIDTH-1; further glitches leave it unchanged.
  - clear_glitch=1 forces it to 0 on the next edge and has priority over a simultaneous increment.
- Counter never exceeds STABLE_CYCLES-1 and never wraps.
- Reset asserted mid-wait: everything returns to reset values immediately. The output goes to 1 even if it was 0.
- Unreachable state encodings must recover to RELEASED with signal_debounced_n=1.

Decomposition:
- Package debounce_pkg holds:
  - the 2-bit state encoding: RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3
  - the reset constant for the active-low level (1'b1)
- One sub-module, sync_2ff: two-flop synchronizer with asynchronous active-low reset to 1. Reused by other input stages.

Test Plan:
All scenarios use STABLE_CYCLES=4 and GLITCH_WIDTH=3.
1. Reset: hold reset_n=0 with signal_raw_n=0 -> signal_debounced_n=1 and glitch_count=0 for the whole reset. Release reset -> output falls exactly 6 edges later.
2. Clean press and release: raw 1->0, held 20 cycles, then 0->1 -> output falls 6 edges after the fall and rises 6 edges after the rise; glitch_count stays 0.
3. Bounce: raw low 2 cycles, high 1, low 3, high 1, then low steady -> glitch_count=2 and output falls 6 edges after the final fall, with no earlier change.
4. Saturation and clear: 9 short low pulses (2 cycles each) -> glitch_count=7 and stays 7. Then clear_glitch together with a 10th glitch -> glitch_count=0.
5. Reset mid-operation: press accepted (output 0), then in RELEASE_WAIT with cnt=2 pulse reset_n low for 1 cycle -> output 1 asynchronously, state RELEASED, counter 0.
6. Release-side glitch: while PRESSED, raw goes high for 3 cycles then back low -> output stays 0 and glitch_count increments by 1.
